sm_cfg_loader: RTL and testbench
================================

Name: sm_cfg_loader

Overview:
Serial configuration loader for the 5x4 switch-matrix tile. It receives a framed bitstream, assembles the 18 routing entries into a shadow store, checks a CRC-8 and the legality of every entry, then commits all entries to the active configuration outputs in a single cycle. The active outputs drive the tile's per-pin select registers (top, bottom, left, right); all-zero means every pin is released (high-Z).

Parameters:
N_TB, 5, pins on the top side and pins on the bottom side
N_LR, 4, pins on the left side and pins on the right side
ENTRY_W, 6, entry width: [5:3] = source pin index, [2:0] = source side code
SYNC, 8'hA5, frame sync word

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  serial bit valid
cfg_bit  input  1  serial data bit, MSB first
cfg_ready  output  1  loader can accept a bit this cycle
cfg_top  output  N_TB*ENTRY_W  active entries for the top pins; pin i at [i*6+:6]
cfg_bottom  output  N_TB*ENTRY_W  active entries for the bottom pins
cfg_left  output  N_LR*ENTRY_W  active entries for the left pins
cfg_right  output  N_LR*ENTRY_W  active entries for the right pins
busy  output  1  frame in progress (state is not HUNT)
cfg_done  output  1  one-cycle pulse: commit succeeded
cfg_err  output  1  one-cycle pulse: frame rejected
err_code  output  2  01 = CRC mismatch, 10 = illegal entry; held until the next frame ends

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all cfg_* outputs 0, shadow store 0, cfg_done 0, cfg_err 0, err_code 0, busy 0, cfg_ready 1, state HUNT, sync shift register 0.
- A bit transfers on a rising edge where cfg_valid && cfg_ready. cfg_ready is 1 in every state except CHECK. No transfer occurs on other edges.
- Frame layout: SYNC (8 bits), then payload of 108 bits, then CRC (8 bits).
  - Payload entry order: top[0..4], bottom[0..4], left[0..3], right[0..3].
  - Each entry is 6 bits, MSB first.
- Side codes: 0 = none, 1 = top, 2 = right, 3 = bottom, 4 = left, 5..7 = illegal.
- HUNT:
  - Each accepted bit shifts into an 8-bit register.
  - When the updated value equals SYNC, go to PAYLOAD and clear the bit counter and CRC.
  - Overlapping sync search is permitted.
- PAYLOAD:
  - Accepted bits shift into the shadow store and update the CRC.
  - After the 108th bit, go to RXCRC.
- CRC definition: CRC-8, polynomial 0x07, init 0x00, serial, payload bits only.
  - fb = crc[7] ^ bit
  - crc_next = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00)
- RXCRC: 8 accepted bits (MSB first) are captured; after the 8th, go to CHECK.
- CHECK (exactly one cycle, cfg_ready = 0):
  - CRC check: computed CRC must equal received CRC, otherwise error 01.
  - Entry legality, applied to every entry:
    - side 0 is legal regardless of index;
    - sides 1 and 3 require index < N_TB;
    - sides 2 and 4 require index < N_LR;
    - sides 5..7 are illegal;
    - an entry selecting its own pin (e.g. top[2] sourced from top index 2) is illegal.
    - Any failure gives error 10.
  - Priority: CRC error (01) over illegal entry (10).
  - On pass: all cfg_* outputs are loaded from the shadow store at the same edge, cfg_done is set, err_code is set to 00.
  - On fail: active outputs are unchanged, cfg_err is set, err_code is set to the failure code.
  - Next state is HUNT, with the sync register cleared.
- Latency: last CRC bit accepted at edge t. CHECK is the cycle after t. New outputs and the cfg_done or cfg_err pulse are visible one cycle later, for exactly one cycle.
- Stalls: cfg_valid = 0 mid-frame holds all state indefinitely. There is no timeout.
- Reset asserted mid-frame: immediate return to the reset values; the active configuration is cleared to 0.
- Outputs change only at reset or at a successful commit. There is never a partially updated configuration.

Decomposition:
- Package sm_cfg_pkg holds:
  - side-code constants (SIDE_NONE, SIDE_TOP, SIDE_RIGHT, SIDE_BOTTOM, SIDE_LEFT);
  - ENTRY_W, SYNC, CRC_POLY;
  - the state enum (HUNT, PAYLOAD, RXCRC, CHECK);
  - the err_code values.
- One sub-module, sm_crc8_serial: clear and enable inputs, bit input, 8-bit crc output.
- The legality checker is combinational logic inside sm_cfg_loader.

Test Plan:
1. Reset, then frame A5 + 108 zeros + CRC 00 -> cfg_done pulse 2 cycles after the last bit; all outputs 0; err_code 00.
2. Frame with top[0] = 6'b001_010 (right[1]) and left[3] = 6'b100_011 (bottom[4]), all others 0, with model-computed CRC -> cfg_top[5:0] = 0x0A, cfg_left[23:18] = 0x23, cfg_done = 1.
3. Same frame as 2 with the CRC LSB flipped -> cfg_err pulse, err_code 01, outputs keep their previous values.
4. Illegal entries, each with a valid CRC -> cfg_err, err_code 10, no commit:
   - right[0] = 6'b100_010 (right index 4 >= N_LR);
   - bottom[1] = side 6;
   - top[2] = 6'b010_001 (self-loop).
5. Leading noise 1,0,1 then A5 overlapping a prefix; cfg_valid dropped for 20 cycles mid-payload -> frame still decodes and commits correctly; cfg_ready = 0 only in the CHECK cycle.
6. rst_n asserted at payload bit 50 after a prior successful commit -> outputs 0 immediately; busy = 0; the next full frame commits normally.

Source files
------------

// File: rtl/sm_cfg_pkg.sv
// Shared constants, types and the entry legality rule for the switch-matrix
// configuration loader.
package sm_cfg_pkg;

    localparam int N_TB      = 5;
    localparam int N_LR      = 4;
    localparam int ENTRY_W   = 6;
    localparam int N_ENTRIES = 2 * N_TB + 2 * N_LR;
    localparam int PAYLOAD_W = N_ENTRIES * ENTRY_W;
    localparam int CRC_W     = 8;
    localparam int CNT_W     = 7;

    localparam logic [7:0]       SYNC     = 8'hA5;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    localparam logic [CNT_W-1:0] CNT_PAYLOAD_LAST = CNT_W'(PAYLOAD_W - 1);
    localparam logic [CNT_W-1:0] CNT_CRC_LAST     = CNT_W'(CRC_W - 1);

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        RXCRC,
        CHECK
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CRC     = 2'b01,
        ERR_ILLEGAL = 2'b10
    } err_e;

    // An entry is legal when its source exists on that side and is not the pin itself.
    function automatic logic entry_legal(input logic [ENTRY_W-1:0] entry,
                                         input logic [2:0]         own_side,
                                         input logic [2:0]         own_idx);
        logic [2:0] idx;
        logic [2:0] side;
        logic       ok;
        idx  = entry[5:3];
        side = entry[2:0];
        case (side)
            SIDE_NONE:               ok = 1'b1;
            SIDE_TOP, SIDE_BOTTOM:   ok = (int'(idx) < N_TB);
            SIDE_RIGHT, SIDE_LEFT:   ok = (int'(idx) < N_LR);
            default:                 ok = 1'b0;
        endcase
        if (side != SIDE_NONE && side == own_side && idx == own_idx) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/sm_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00) over the configuration payload.
module sm_crc8_serial
    import sm_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic             fb;

    always_comb begin
        fb    = crc_q[CRC_W-1] ^ bit_i;
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sm_cfg_loader.sv
// Serial configuration loader: hunts for the sync word, collects 18 routing
// entries plus CRC, validates them and commits all entries in one cycle.
module sm_cfg_loader
    import sm_cfg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    input  logic                    cfg_bit,
    output logic                    cfg_ready,
    output logic [N_TB*ENTRY_W-1:0] cfg_top,
    output logic [N_TB*ENTRY_W-1:0] cfg_bottom,
    output logic [N_LR*ENTRY_W-1:0] cfg_left,
    output logic [N_LR*ENTRY_W-1:0] cfg_right,
    output logic                    busy,
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic [1:0]              err_code
);

    state_e                  state_q, state_d;
    logic [7:0]              sync_q, sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0]    shadow_q, shadow_d;
    logic [CRC_W-1:0]        rxcrc_q, rxcrc_d;
    logic [N_TB*ENTRY_W-1:0] top_q, top_d, bottom_q, bottom_d;
    logic [N_LR*ENTRY_W-1:0] left_q, left_d, right_q, right_d;
    logic                    done_q, done_d, err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;

    logic                    xfer;
    logic                    crc_clr, crc_en;
    logic [CRC_W-1:0]        crc_calc;
    logic                    all_legal;

    logic [N_TB*ENTRY_W-1:0] shadow_top, shadow_bottom;
    logic [N_LR*ENTRY_W-1:0] shadow_left, shadow_right;

    // The first payload bit ends up at the MSB of the shadow store.
    for (genvar g = 0; g < N_TB; g++) begin : g_tb_map
        assign shadow_top[g*ENTRY_W +: ENTRY_W]    = shadow_q[PAYLOAD_W-1-g*ENTRY_W -: ENTRY_W];
        assign shadow_bottom[g*ENTRY_W +: ENTRY_W] = shadow_q[PAYLOAD_W-1-(N_TB+g)*ENTRY_W -: ENTRY_W];
    end
    for (genvar g = 0; g < N_LR; g++) begin : g_lr_map
        assign shadow_left[g*ENTRY_W +: ENTRY_W]  = shadow_q[PAYLOAD_W-1-(2*N_TB+g)*ENTRY_W -: ENTRY_W];
        assign shadow_right[g*ENTRY_W +: ENTRY_W] = shadow_q[PAYLOAD_W-1-(2*N_TB+N_LR+g)*ENTRY_W -: ENTRY_W];
    end

    always_comb begin
        all_legal = 1'b1;
        for (int i = 0; i < N_TB; i++) begin
            if (!entry_legal(shadow_top[i*ENTRY_W +: ENTRY_W], SIDE_TOP, 3'(i)))       all_legal = 1'b0;
            if (!entry_legal(shadow_bottom[i*ENTRY_W +: ENTRY_W], SIDE_BOTTOM, 3'(i))) all_legal = 1'b0;
        end
        for (int i = 0; i < N_LR; i++) begin
            if (!entry_legal(shadow_left[i*ENTRY_W +: ENTRY_W], SIDE_LEFT, 3'(i)))     all_legal = 1'b0;
            if (!entry_legal(shadow_right[i*ENTRY_W +: ENTRY_W], SIDE_RIGHT, 3'(i)))   all_legal = 1'b0;
        end
    end

    sm_crc8_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (cfg_bit),
        .crc_o (crc_calc)
    );

    assign cfg_ready = (state_q != CHECK);
    assign xfer      = cfg_valid && cfg_ready;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path leaves a latch behind.
        state_d    = state_q;
        sync_d     = sync_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        rxcrc_d    = rxcrc_q;
        top_d      = top_q;
        bottom_d   = bottom_q;
        left_d     = left_q;
        right_d    = right_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        case (state_q)
            HUNT: begin
                if (xfer) begin
                    // NOTE: blocking here, so sync_d below already holds the updated window.
                    sync_d = {sync_q[6:0], cfg_bit};
                    if (sync_d == SYNC) begin
                        state_d = PAYLOAD;
                        cnt_d   = '0;
                        crc_clr = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    shadow_d = {shadow_q[PAYLOAD_W-2:0], cfg_bit};
                    crc_en   = 1'b1;
                    if (cnt_q == CNT_PAYLOAD_LAST) begin
                        state_d = RXCRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RXCRC: begin
                if (xfer) begin
                    rxcrc_d = {rxcrc_q[CRC_W-2:0], cfg_bit};
                    if (cnt_q == CNT_CRC_LAST) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = HUNT;
                sync_d  = '0;
                if (crc_calc != rxcrc_q) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_CRC;
                end else if (!all_legal) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_ILLEGAL;
                end else begin
                    top_d      = shadow_top;
                    bottom_d   = shadow_bottom;
                    left_d     = shadow_left;
                    right_d    = shadow_right;
                    done_d     = 1'b1;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            sync_q     <= '0;
            cnt_q      <= '0;
            // NOTE: the shadow store is a register bank with a defined reset value, not a RAM.
            shadow_q   <= '0;
            rxcrc_q    <= '0;
            top_q      <= '0;
            bottom_q   <= '0;
            left_q     <= '0;
            right_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            rxcrc_q    <= rxcrc_d;
            top_q      <= top_d;
            bottom_q   <= bottom_d;
            left_q     <= left_d;
            right_q    <= right_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign cfg_top    = top_q;
    assign cfg_bottom = bottom_q;
    assign cfg_left   = left_q;
    assign cfg_right  = right_q;
    assign busy       = (state_q != HUNT);
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_sm_cfg_loader.sv
// Randomised frame-level bench for sm_cfg_loader against a behavioural model
// of the active configuration, CRC and entry legality.
module tb_sm_cfg_loader;
    import sm_cfg_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cfg_valid = 1'b0;
    logic                    cfg_bit = 1'b0;
    logic                    cfg_ready;
    logic [N_TB*ENTRY_W-1:0] cfg_top, cfg_bottom;
    logic [N_LR*ENTRY_W-1:0] cfg_left, cfg_right;
    logic                    busy, cfg_done, cfg_err;
    logic [1:0]              err_code;

    always #5 clk = ~clk;

    sm_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .cfg_top    (cfg_top),
        .cfg_bottom (cfg_bottom),
        .cfg_left   (cfg_left),
        .cfg_right  (cfg_right),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .err_code   (err_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0]  ent [18];
    logic [29:0] exp_top, exp_bottom;
    logic [23:0] exp_left, exp_right;
    logic [1:0]  exp_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Remainder of payload * x^8 divided by x^8 + x^2 + x + 1, by long division.
    function automatic logic [7:0] model_crc();
        logic       m [116];
        logic [8:0] poly;
        logic [7:0] r;
        int         p;
        poly = 9'h107;
        p = 0;
        for (int k = 0; k < 18; k++)
            for (int b = 5; b >= 0; b--) begin
                m[p] = ent[k][b];
                p++;
            end
        for (int i = 108; i < 116; i++) m[i] = 1'b0;
        for (int i = 0; i < 108; i++)
            if (m[i])
                for (int j = 0; j <= 8; j++) m[i+j] = m[i+j] ^ poly[8-j];
        for (int i = 0; i < 8; i++) r[7-i] = m[108+i];
        return r;
    endfunction

    function automatic logic model_legal();
        int own_side, own_idx, side, idx, limit;
        for (int k = 0; k < 18; k++) begin
            if (k < 5)       begin own_side = 1; own_idx = k;      end
            else if (k < 10) begin own_side = 3; own_idx = k - 5;  end
            else if (k < 14) begin own_side = 4; own_idx = k - 10; end
            else             begin own_side = 2; own_idx = k - 14; end
            idx  = int'(ent[k][5:3]);
            side = int'(ent[k][2:0]);
            if (side == 0) continue;
            if (side > 4) return 1'b0;
            limit = (side == 1 || side == 3) ? 5 : 4;
            if (idx >= limit) return 1'b0;
            if (side == own_side && idx == own_idx) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, "_top"},    cfg_top,    exp_top);
        check({pfx, "_bottom"}, cfg_bottom, exp_bottom);
        check({pfx, "_left"},   cfg_left,   exp_left);
        check({pfx, "_right"},  cfg_right,  exp_right);
        check({pfx, "_code"},   err_code,   exp_code);
    endtask

    task automatic send_bit(input logic b);
        int guard;
        cfg_bit   = b;
        cfg_valid = 1'b1;
        guard     = 0;
        while (!cfg_ready && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cfg_ready) check("ready_timeout", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic expect_result(input logic flip);
        logic legal, ok;
        logic [1:0] code;
        legal = model_legal();
        code  = flip ? 2'b01 : (!legal ? 2'b10 : 2'b00);
        ok    = (code == 2'b00);
        @(negedge clk);
        check("chk_ready", cfg_ready, 0);
        check("chk_busy",  busy,      1);
        check("chk_early", {cfg_done, cfg_err}, 0);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                exp_top[i*6 +: 6]    = ent[i];
                exp_bottom[i*6 +: 6] = ent[5+i];
            end
            for (int i = 0; i < 4; i++) begin
                exp_left[i*6 +: 6]  = ent[10+i];
                exp_right[i*6 +: 6] = ent[14+i];
            end
        end
        exp_code = code;
        @(negedge clk);
        check("res_done", cfg_done, ok);
        check("res_err",  cfg_err,  !ok);
        check_outputs("res");
        check("res_ready", cfg_ready, 1);
        check("res_busy",  busy,      0);
        @(negedge clk);
        check("pulse_end", {cfg_done, cfg_err}, 0);
    endtask

    task automatic do_abort();
        #2 rst_n = 1'b0;
        #1;
        exp_top = '0; exp_bottom = '0; exp_left = '0; exp_right = '0; exp_code = '0;
        check_outputs("rst_mid");
        check("rst_mid_busy",  busy,      0);
        check("rst_mid_ready", cfg_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic noise, input logic flip, input int stall_at, input int abort_at);
        logic [7:0] sw, crc;
        int idx;
        sw = SYNC;
        if (noise) begin
            send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        end
        for (int i = 7; i >= 0; i--) send_bit(sw[i]);
        idx = 0;
        for (int k = 0; k < 18; k++)
            for (int b = 5; b >= 0; b--) begin
                if (idx == abort_at) begin
                    do_abort();
                    return;
                end
                if (idx == stall_at) begin
                    repeat (20) @(posedge clk);
                    #1;
                    check("stall_busy",  busy,      1);
                    check("stall_ready", cfg_ready, 1);
                    check("stall_top",   cfg_top,   exp_top);
                end
                send_bit(ent[k][b]);
                idx++;
            end
        crc = model_crc();
        if (flip) crc[0] = ~crc[0];
        for (int i = 7; i >= 0; i--) send_bit(crc[i]);
        expect_result(flip);
    endtask

    task automatic rand_legal_frame();
        int side, lim;
        for (int k = 0; k < 18; k++) begin
            side = $urandom_range(0, 4);
            lim  = (side == 1 || side == 3) ? 5 : 4;
            ent[k] = {3'($urandom_range(0, lim - 1)), 3'(side)};
            if (side == 0) ent[k][5:3] = 3'($urandom_range(0, 7));
        end
        // A self-selecting pin is replaced by a released one.
        if (!model_legal())
            for (int k = 0; k < 18; k++) begin
                logic [5:0] keep;
                keep = ent[k];
                ent[k] = '0;
                if (model_legal()) break;
                ent[k] = keep;
            end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 18; k++) ent[k] = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_top = '0; exp_bottom = '0; exp_left = '0; exp_right = '0; exp_code = '0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        check_outputs("reset");
        check("reset_ready", cfg_ready, 1);
        check("reset_busy",  busy,      0);
        check("reset_pulse", {cfg_done, cfg_err}, 0);
        @(posedge clk); #1;

        // All-zero frame.
        clear_frame();
        send_frame(1'b0, 1'b0, -1, -1);

        // Two routed pins, then the same frame with a corrupted CRC.
        clear_frame();
        ent[0]  = 6'b001_010;
        ent[13] = 6'b100_011;
        send_frame(1'b0, 1'b0, -1, -1);
        check("t2_top0",  cfg_top[5:0],    6'h0A);
        check("t2_left3", cfg_left[23:18], 6'h23);
        send_frame(1'b0, 1'b1, -1, -1);

        // Illegal entries with valid CRCs.
        clear_frame(); ent[14] = 6'b100_010; send_frame(1'b0, 1'b0, -1, -1);
        clear_frame(); ent[6]  = 6'b000_110; send_frame(1'b0, 1'b0, -1, -1);
        clear_frame(); ent[2]  = 6'b010_001; send_frame(1'b0, 1'b0, -1, -1);

        // Leading noise plus a long mid-payload stall.
        rand_legal_frame();
        send_frame(1'b1, 1'b0, 40, -1);

        // Reset in mid-payload after a commit, then a clean frame.
        rand_legal_frame();
        send_frame(1'b0, 1'b0, -1, -1);
        rand_legal_frame();
        send_frame(1'b0, 1'b0, -1, 50);
        rand_legal_frame();
        send_frame(1'b0, 1'b0, -1, -1);

        // Random frames: mostly legal, some with a random entry or a bad CRC.
        for (int f = 0; f < 12; f++) begin
            int mode, stall;
            rand_legal_frame();
            mode = $urandom_range(0, 99);
            if (mode < 25) ent[$urandom_range(0, 17)] = 6'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 107)) : -1;
            send_frame(1'b0, mode >= 85, stall, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
